// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the alu3 entry sequencer and its display driver.
// State codes are fixed because the display shows them directly.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  function automatic logic op_is_legal(input logic [1:0] op);
    return op != OP_BAD;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises a raw push button, filters bounce with a stability counter and
// emits a one-cycle press pulse on each accepted 0->1 edge of the filtered level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk100mhz,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      // cnt counts consecutive synced samples that disagree with the accepted level
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        press <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_entry_sequencer.sv
// Steps the user through A -> B -> op entry for alu3, waits ALU_LAT cycles for
// the ALU to settle, then holds the captured result until the next confirm.
module alu_entry_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned ALU_LAT         = 1
) (
  input  logic       clk100mhz,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_clr,
  input  logic [2:0] sw_val,
  input  logic [1:0] sw_op,
  input  logic       sw_dir,
  input  logic [5:0] y6_in,
  input  logic       sign_in,
  output logic [2:0] a_q,
  output logic [2:0] b_q,
  output logic [1:0] op_q,
  output logic       dir_q,
  output logic [2:0] state_o,
  output logic [5:0] result_q,
  output logic       sign_q,
  output logic       result_vld,
  output logic       err_pulse
);

  localparam int unsigned LW = $clog2(ALU_LAT + 1);

  logic          next_press;
  logic          clr_press;
  logic          next_level;
  logic          clr_level;
  logic          unused_levels;
  state_e        state_q;
  logic [LW-1:0] lat_cnt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_next_db (
    .clk100mhz(clk100mhz),
    .rst      (rst),
    .raw      (btn_next),
    .level    (next_level),
    .press    (next_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clr_db (
    .clk100mhz(clk100mhz),
    .rst      (rst),
    .raw      (btn_clr),
    .level    (clr_level),
    .press    (clr_press)
  );

  // Only the press pulses matter here; the levels are kept for the display driver later.
  assign unused_levels = next_level ^ clr_level;

  assign state_o = state_q;

  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      state_q    <= S_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      dir_q      <= 1'b0;
      result_q   <= '0;
      sign_q     <= 1'b0;
      result_vld <= 1'b0;
      err_pulse  <= 1'b0;
      lat_cnt    <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (clr_press) begin
        // Clear wins over a coincident next and aborts an in-flight execution.
        state_q    <= S_A;
        a_q        <= '0;
        b_q        <= '0;
        op_q       <= OP_ADD;
        dir_q      <= 1'b0;
        result_q   <= '0;
        sign_q     <= 1'b0;
        result_vld <= 1'b0;
        lat_cnt    <= '0;
      end else begin
        case (state_q)
          S_A: begin
            if (next_press) begin
              a_q     <= sw_val;
              state_q <= S_B;
            end
          end
          S_B: begin
            if (next_press) begin
              b_q     <= sw_val;
              state_q <= S_OP;
            end
          end
          S_OP: begin
            if (next_press) begin
              if (op_is_legal(sw_op)) begin
                op_q    <= sw_op;
                dir_q   <= sw_dir;
                lat_cnt <= LW'(ALU_LAT);
                state_q <= S_EXEC;
              end else begin
                err_pulse <= 1'b1;
              end
            end
          end
          S_EXEC: begin
            if (lat_cnt == LW'(1)) begin
              result_q   <= y6_in;
              sign_q     <= (op_q == OP_SUB) & sign_in;
              result_vld <= 1'b1;
              state_q    <= S_SHOW;
            end else begin
              lat_cnt <= lat_cnt - LW'(1);
            end
          end
          S_SHOW: begin
            if (next_press) begin
              result_vld <= 1'b0;
              state_q    <= S_A;
            end
          end
          default: state_q <= S_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_entry_sequencer.sv
// Drives two sequencers (ALU_LAT=1 and 3) from shared buttons/switches, each wired
// to a behavioural alu3, and checks them every cycle against a spec-level model.
module tb_alu_entry_sequencer;

  localparam int DB = 4;
  localparam int HN = 8192;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_next;
  logic       btn_clr;
  logic [2:0] sw_val;
  logic [1:0] sw_op;
  logic       sw_dir;

  logic [2:0] a_q        [2];
  logic [2:0] b_q        [2];
  logic [1:0] op_q       [2];
  logic       dir_q      [2];
  logic [2:0] state_o    [2];
  logic [5:0] result_q   [2];
  logic       sign_q     [2];
  logic       result_vld [2];
  logic       err_pulse  [2];
  logic [5:0] y6         [2];
  logic       sgn_in     [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // alu3 stand-in: add, sub (magnitude, borrow always reported), mul, illegal -> 0
  function automatic logic [6:0] alu3_f(input logic [2:0] a, input logic [2:0] b,
                                        input logic [1:0] op, input logic dir);
    logic [5:0] x, y, r;
    logic       brw;
    x   = dir ? {3'b0, b} : {3'b0, a};
    y   = dir ? {3'b0, a} : {3'b0, b};
    brw = x < y;
    case (op)
      2'b00:   r = {3'b0, a} + {3'b0, b};
      2'b01:   r = brw ? y - x : x - y;
      2'b10:   r = {3'b0, a} * {3'b0, b};
      default: r = 6'd0;
    endcase
    return {brw, r};
  endfunction

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_entry_sequencer #(
      .DEBOUNCE_CYCLES(DB),
      .ALU_LAT        (lat_of(g))
    ) u_dut (
      .clk100mhz (clk),
      .rst       (rst),
      .btn_next  (btn_next),
      .btn_clr   (btn_clr),
      .sw_val    (sw_val),
      .sw_op     (sw_op),
      .sw_dir    (sw_dir),
      .y6_in     (y6[g]),
      .sign_in   (sgn_in[g]),
      .a_q       (a_q[g]),
      .b_q       (b_q[g]),
      .op_q      (op_q[g]),
      .dir_q     (dir_q[g]),
      .state_o   (state_o[g]),
      .result_q  (result_q[g]),
      .sign_q    (sign_q[g]),
      .result_vld(result_vld[g]),
      .err_pulse (err_pulse[g])
    );
    assign {sgn_in[g], y6[g]} = alu3_f(a_q[g], b_q[g], op_q[g], dir_q[g]);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_st[2], m_a[2], m_b[2], m_op[2], m_dir[2], m_res[2], m_sgn[2], m_vld[2], m_err[2];
  int m_start[2];
  bit hist[2][HN];
  bit lvl[2], prs[2], raw_s[2];
  bit all_eq;
  int cyc = 0;
  logic [6:0] alu_exp;

  always @(posedge clk) begin : model
    // FSM reacts to the press pulses produced at the previous edge.
    for (int g = 0; g < 2; g++) begin
      m_err[g] = 0;
      if (rst || prs[1]) begin
        m_st[g] = 0; m_a[g] = 0; m_b[g] = 0; m_op[g] = 0; m_dir[g] = 0;
        m_res[g] = 0; m_sgn[g] = 0; m_vld[g] = 0;
      end else begin
        case (m_st[g])
          0: if (prs[0]) begin m_a[g] = int'(sw_val); m_st[g] = 1; end
          1: if (prs[0]) begin m_b[g] = int'(sw_val); m_st[g] = 2; end
          2: if (prs[0]) begin
            if (sw_op == 2'b11) m_err[g] = 1;
            else begin
              m_op[g] = int'(sw_op); m_dir[g] = int'(sw_dir);
              m_start[g] = cyc; m_st[g] = 3;
            end
          end
          3: if (cyc == m_start[g] + lat_of(g)) begin
            alu_exp = alu3_f(3'(m_a[g]), 3'(m_b[g]), 2'(m_op[g]), 1'(m_dir[g]));
            m_res[g] = int'(alu_exp[5:0]);
            m_sgn[g] = (m_op[g] == 1) ? int'(alu_exp[6]) : 0;
            m_vld[g] = 1;
            m_st[g]  = 4;
          end
          default: if (prs[0]) begin m_vld[g] = 0; m_st[g] = 0; end
        endcase
      end
    end
    // Button model: a level change needs DB equal samples of the raw input seen 2 edges late.
    raw_s[0] = btn_next;
    raw_s[1] = btn_clr;
    for (int b = 0; b < 2; b++) begin
      prs[b] = 0;
      if (rst) begin
        hist[b][cyc] = 0;
        if (cyc > 0) hist[b][cyc-1] = 0;
        lvl[b] = 0;
      end else begin
        hist[b][cyc] = raw_s[b];
        if (cyc >= DB + 1) begin
          all_eq = 1;
          for (int j = cyc - 1 - DB; j <= cyc - 2; j++)
            if (hist[b][j] != hist[b][cyc-2]) all_eq = 0;
          if (all_eq && hist[b][cyc-2] != lvl[b]) begin
            lvl[b] = hist[b][cyc-2];
            prs[b] = lvl[b];
          end
        end
      end
    end
    if (cyc < HN - 1) cyc++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    for (int g = 0; g < 2; g++) begin
      check($sformatf("state[%0d]", g),  8'(state_o[g]),    8'(m_st[g]));
      check($sformatf("a_q[%0d]", g),    8'(a_q[g]),        8'(m_a[g]));
      check($sformatf("b_q[%0d]", g),    8'(b_q[g]),        8'(m_b[g]));
      check($sformatf("op_q[%0d]", g),   8'(op_q[g]),       8'(m_op[g]));
      check($sformatf("dir_q[%0d]", g),  8'(dir_q[g]),      8'(m_dir[g]));
      check($sformatf("result[%0d]", g), 8'(result_q[g]),   8'(m_res[g]));
      check($sformatf("sign[%0d]", g),   8'(sign_q[g]),     8'(m_sgn[g]));
      check($sformatf("vld[%0d]", g),    8'(result_vld[g]), 8'(m_vld[g]));
      check($sformatf("err[%0d]", g),    8'(err_pulse[g]),  8'(m_err[g]));
    end
  end

  // Cumulative event counters; the stimulus diffs snapshots of them.
  int err_cnt[2], exec_cnt[2], vld_cnt[2];
  always @(negedge clk) begin : monitor
    for (int g = 0; g < 2; g++) begin
      if (err_pulse[g] === 1'b1) err_cnt[g]++;
      if (state_o[g] === 3'd3) exec_cnt[g]++;
      if (result_vld[g] === 1'b1) vld_cnt[g]++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    btn_next = 1'b1;
    wait_cyc(8);
    btn_next = 1'b0;
    wait_cyc(8);
  endtask

  task automatic enter(input logic [2:0] a, input logic [2:0] b,
                       input logic [1:0] op, input logic dir);
    sw_val = a; press();
    sw_val = b; press();
    sw_op = op; sw_dir = dir; press();
  endtask

  int snap[2];

  initial begin
    rst = 1'b1; btn_next = 1'b0; btn_clr = 1'b0;
    sw_val = '0; sw_op = '0; sw_dir = 1'b0;
    wait_cyc(3);
    check("reset state",  8'(state_o[0]),    8'd0);
    check("reset vld",    8'(result_vld[1]), 8'd0);
    rst = 1'b0;
    wait_cyc(2);

    // Add 5+3, and S_EXEC length equals ALU_LAT
    snap[0] = exec_cnt[0]; snap[1] = exec_cnt[1];
    enter(3'd5, 3'd3, 2'b00, 1'b0);
    check("add result L1", 8'(result_q[0]), 8'd8);
    check("add result L3", 8'(result_q[1]), 8'd8);
    check("add sign",      8'(sign_q[0]),   8'd0);
    check("add vld",       8'(result_vld[1]), 8'd1);
    check("add state",     8'(state_o[1]),  8'd4);
    check("exec len L1",   8'(exec_cnt[0] - snap[0]), 8'd1);
    check("exec len L3",   8'(exec_cnt[1] - snap[1]), 8'd3);
    press();
    check("show->A state", 8'(state_o[0]),    8'd0);
    check("show->A vld",   8'(result_vld[0]), 8'd0);
    check("a kept",        8'(a_q[1]),        8'd5);

    enter(3'd7, 3'd7, 2'b10, 1'b0);
    check("mul result", 8'(result_q[1]), 8'd49);
    press();

    enter(3'd2, 3'd6, 2'b01, 1'b0);
    check("sub A-B sign",   8'(sign_q[0]),   8'd1);
    check("sub A-B result", 8'(result_q[1]), 8'd4);
    press();

    enter(3'd2, 3'd6, 2'b01, 1'b1);
    check("sub B-A sign",   8'(sign_q[1]),   8'd0);
    check("sub B-A result", 8'(result_q[0]), 8'd4);
    press();

    // Illegal op: one err pulse, stays in S_OP, op_q keeps the previous sub
    sw_val = 3'd1; press();
    sw_val = 3'd2; press();
    snap[0] = err_cnt[0]; snap[1] = err_cnt[1];
    sw_op = 2'b11; sw_dir = 1'b0; press();
    check("illegal err L1", 8'(err_cnt[0] - snap[0]), 8'd1);
    check("illegal err L3", 8'(err_cnt[1] - snap[1]), 8'd1);
    check("illegal state",  8'(state_o[0]), 8'd2);
    check("illegal op_q",   8'(op_q[1]),     8'd1);
    sw_op = 2'b00; press();
    check("after illegal result", 8'(result_q[1]), 8'd3);
    press();

    // Borrow on an add must not reach sign_q
    enter(3'd2, 3'd6, 2'b00, 1'b0);
    check("add gate sign",   8'(sign_q[0]),   8'd0);
    check("add gate result", 8'(result_q[0]), 8'd8);
    press();

    // Bounce: two 3-cycle highs are rejected; a long hold yields one press
    btn_next = 1'b1; wait_cyc(3);
    btn_next = 1'b0; wait_cyc(1);
    btn_next = 1'b1; wait_cyc(3);
    btn_next = 1'b0; wait_cyc(12);
    check("bounce state", 8'(state_o[0]), 8'd0);
    sw_val = 3'd4;
    btn_next = 1'b1; wait_cyc(20);
    btn_next = 1'b0; wait_cyc(8);
    check("hold one press", 8'(state_o[1]), 8'd1);
    check("hold a_q",       8'(a_q[0]),     8'd4);

    // Clear and next together in S_B
    sw_val = 3'd5;
    btn_next = 1'b1; btn_clr = 1'b1; wait_cyc(8);
    btn_next = 1'b0; btn_clr = 1'b0; wait_cyc(8);
    check("clr prio state",  8'(state_o[0]),  8'd0);
    check("clr prio a_q",    8'(a_q[0]),      8'd0);
    check("clr prio b_q",    8'(b_q[1]),      8'd0);
    check("clr prio result", 8'(result_q[1]), 8'd0);

    // Clear lands while the ALU_LAT=3 instance is still executing
    sw_val = 3'd3; press();
    sw_val = 3'd4; press();
    sw_op = 2'b00;
    snap[1] = vld_cnt[1];
    btn_next = 1'b1; wait_cyc(2);
    btn_clr  = 1'b1; wait_cyc(6);
    btn_next = 1'b0; wait_cyc(2);
    btn_clr  = 1'b0; wait_cyc(10);
    check("abort no vld L3", 8'(vld_cnt[1] - snap[1]), 8'd0);
    check("abort state L3",  8'(state_o[1]), 8'd0);
    check("abort a_q L1",    8'(a_q[0]),     8'd0);

    // Synchronous reset: a glitch between edges is ignored, a sampled one clears all
    enter(3'd1, 3'd1, 2'b00, 1'b0);
    @(negedge clk); #1 rst = 1'b1; #2 rst = 1'b0;
    wait_cyc(2);
    check("rst glitch state", 8'(state_o[0]),    8'd4);
    check("rst glitch vld",   8'(result_vld[1]), 8'd1);
    rst = 1'b1; wait_cyc(1);
    rst = 1'b0;
    check("rst state",  8'(state_o[1]),    8'd0);
    check("rst result", 8'(result_q[0]),   8'd0);
    check("rst a_q",    8'(a_q[1]),        8'd0);
    check("rst vld",    8'(result_vld[0]), 8'd0);
    wait_cyc(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
